// File: rtl/dmem_responder_if.sv
// Tagged data-memory bus between the data cache (master) and the memory
// responder (slave).
//   proc2Dmem_command  : 0 none, 1 load, 2 store, 3 treated as none
//   proc2Dmem_addr     : byte address, bits [2:0] ignored by the responder
//   proc2Dmem_data     : store data (64b doubleword)
//   Dmem2proc_response : combinational accept tag, 0 = not accepted
//   Dmem2proc_data     : registered load completion data
//   Dmem2proc_tag      : registered completing tag, 0 = none
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic [1:0]      proc2Dmem_command;
    logic [XLEN-1:0] proc2Dmem_addr;
    logic [63:0]     proc2Dmem_data;
    logic [3:0]      Dmem2proc_response;
    logic [63:0]     Dmem2proc_data;
    logic [3:0]      Dmem2proc_tag;

    modport master (
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
    );

    modport slave (
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: memory end of the tagged proc2Dmem/Dmem2proc bus.
// Accepts loads/stores of 64-bit doublewords, hands back the lowest free tag
// combinationally, and completes each transaction MEM_LATENCY cycles after
// the request cycle by presenting tag (and load data) for one cycle.
// Ports:
//   clock     : system clock
//   reset     : asynchronous, active-high; clears tags/outputs, not storage
//   bus       : slave side of dmem_responder_if
//   tags_busy : bit i-1 set while tag i is in flight (debug)
module dmem_responder #(
    parameter int XLEN           = 32,
    parameter int MEM_LATENCY    = 4,
    parameter int NUM_TAGS       = 15,
    parameter int MEM_DEPTH_BITS = 10
) (
    input  logic                clock,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic [NUM_TAGS-1:0] tags_busy
);
    localparam int            DEPTH    = 1 << MEM_DEPTH_BITS;
    localparam int            CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    logic [63:0]                mem [DEPTH];
    logic [NUM_TAGS-1:0][63:0]  slot_data;
    logic [NUM_TAGS-1:0][CW-1:0] cnt_reg;
    logic [NUM_TAGS-1:0]        busy_reg;
    logic [3:0]                 out_tag_reg;
    logic [63:0]                out_data_reg;

    logic [MEM_DEPTH_BITS-1:0]  idx;
    logic                       is_load;
    logic                       is_store;
    logic                       req;
    logic                       accept;
    logic [3:0]                 alloc_tag;
    logic [3:0]                 sel_tag;
    logic [63:0]                sel_data;
    logic [NUM_TAGS-1:0]        accept_1h;
    logic [NUM_TAGS-1:0]        free_1h;
    logic [NUM_TAGS-1:0]        due;

    // Upper address bits alias modulo the memory depth.
    assign idx      = bus.proc2Dmem_addr[MEM_DEPTH_BITS+2:3];
    assign is_load  = (bus.proc2Dmem_command == 2'd1);
    assign is_store = (bus.proc2Dmem_command == 2'd2);
    // No request is taken while reset is held, so storage is never touched.
    assign req      = (is_load || is_store) && !reset;

    generate
        if (XLEN > MEM_DEPTH_BITS + 3) begin : g_unused_hi
            logic unused_addr_bits;
            assign unused_addr_bits = ^{bus.proc2Dmem_addr[2:0],
                                        bus.proc2Dmem_addr[XLEN-1:MEM_DEPTH_BITS+3]};
        end else begin : g_unused_lo
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.proc2Dmem_addr[2:0];
        end
    endgenerate

    // Lowest-numbered free tag; 0 when every slot is busy.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_reg[i]) alloc_tag = 4'(i + 1);
        end
    end

    assign accept = req && (alloc_tag != 4'd0);

    // The tag currently on the outputs is in its completion cycle: it stays
    // busy (not allocatable) until the edge that ends that cycle, and must not
    // be picked for completion a second time.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_slot
            assign free_1h[gi]   = (out_tag_reg == 4'(gi + 1));
            assign accept_1h[gi] = accept && (alloc_tag == 4'(gi + 1));
            if (MEM_LATENCY == 1) begin : g_bypass
                // A one-cycle latency completes on the accepting edge itself.
                assign due[gi] = (busy_reg[gi] && !free_1h[gi]) || accept_1h[gi];
            end else begin : g_count
                // Due when the countdown reaches 0 at this edge, so the
                // registered outputs land exactly MEM_LATENCY cycles after
                // the request cycle.
                assign due[gi] = busy_reg[gi] && !free_1h[gi] && (cnt_reg[gi] <= CW'(1));
            end
        end
    endgenerate

    // Lowest-numbered due slot wins the completion outputs; others stall.
    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (due[i]) begin
                sel_tag = 4'(i + 1);
                if (MEM_LATENCY == 1 && accept_1h[i]) begin
                    sel_data = is_load ? mem[idx] : 64'd0;
                end else begin
                    sel_data = slot_data[i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_reg     <= '0;
            cnt_reg      <= '0;
            out_tag_reg  <= '0;
            out_data_reg <= '0;
        end else begin
            busy_reg     <= (busy_reg & ~free_1h) | accept_1h;
            out_tag_reg  <= sel_tag;
            out_data_reg <= sel_data;
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (accept_1h[i]) begin
                    cnt_reg[i] <= CNT_LOAD;
                end else if (cnt_reg[i] != '0) begin
                    cnt_reg[i] <= cnt_reg[i] - CW'(1);
                end
            end
        end
    end

    // Storage and per-slot load data carry no reset.
    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem[idx] <= bus.proc2Dmem_data;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (accept_1h[i]) begin
                slot_data[i] <= is_load ? mem[idx] : 64'd0;
            end
        end
    end

    assign bus.Dmem2proc_response = accept ? alloc_tag : 4'd0;
    assign bus.Dmem2proc_tag      = out_tag_reg;
    assign bus.Dmem2proc_data     = out_data_reg;
    assign tags_busy              = busy_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (latency 4 and 20).
// Requests push expected completions; per-instance monitors pop and compare.
module tb_dmem_responder;
    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_STORE = 2'd2;
    localparam logic [1:0] C_BAD   = 2'd3;
    localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D2 = 64'h11112222_33334444;
    localparam logic [63:0] D3 = 64'hA5A5A5A5_5A5A5A5A;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [14:0] busy_a;
    logic [14:0] busy_b;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    exp_t        q_a[$];
    exp_t        q_b[$];

    dmem_responder_if #(.XLEN(32)) bus_a ();
    dmem_responder_if #(.XLEN(32)) bus_b ();

    dmem_responder #(.XLEN(32), .MEM_LATENCY(4), .NUM_TAGS(15), .MEM_DEPTH_BITS(10)) u_dut_a (
        .clock(clk), .reset(rst_a), .bus(bus_a.slave), .tags_busy(busy_a)
    );

    dmem_responder #(.XLEN(32), .MEM_LATENCY(20), .NUM_TAGS(15), .MEM_DEPTH_BITS(10)) u_dut_b (
        .clock(clk), .reset(rst_b), .bus(bus_b.slave), .tags_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_bus(input int d, input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [63:0] wdata);
        if (d == 0) begin
            bus_a.proc2Dmem_command = cmd;
            bus_a.proc2Dmem_addr    = addr;
            bus_a.proc2Dmem_data    = wdata;
        end else begin
            bus_b.proc2Dmem_command = cmd;
            bus_b.proc2Dmem_addr    = addr;
            bus_b.proc2Dmem_data    = wdata;
        end
    endtask

    // Present one request for one cycle; check the combinational response and
    // push the expected completion when the request should be accepted.
    task automatic issue(input int d, input logic [1:0] cmd, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [3:0] exp_resp,
                         input logic [63:0] exp_data, input string name);
        logic [3:0] resp;
        exp_t       e;
        set_bus(d, cmd, addr, wdata);
        @(negedge clk);
        resp = (d == 0) ? bus_a.Dmem2proc_response : bus_b.Dmem2proc_response;
        $display("[%0d] dut%0d req cmd=%0d addr=%h wdata=%h -> response %0d",
                 cyc, d, cmd, addr, wdata, resp);
        chk(name, 64'(resp), 64'(exp_resp));
        if (exp_resp != 4'd0) begin
            e.tag  = exp_resp;
            e.data = exp_data;
            e.cyc  = cyc + ((d == 0) ? 4 : 20);
            if (d == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        set_bus(d, C_NONE, 32'h0, 64'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_busy(input int d, input logic [14:0] exp, input string name);
        @(negedge clk);
        chk(name, 64'((d == 0) ? busy_a : busy_b), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_a && bus_a.Dmem2proc_tag != 4'd0) begin
            $display("[%0d] dut0 completion tag=%0d data=%h", cyc, bus_a.Dmem2proc_tag, bus_a.Dmem2proc_data);
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cpl_a: actual tag %0d required no completion", bus_a.Dmem2proc_tag);
            end else begin
                e = q_a.pop_front();
                chk("cpl_tag_a", 64'(bus_a.Dmem2proc_tag), 64'(e.tag));
                chk("cpl_data_a", bus_a.Dmem2proc_data, e.data);
                chk("cpl_cycle_a", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b && bus_b.Dmem2proc_tag != 4'd0) begin
            $display("[%0d] dut1 completion tag=%0d data=%h", cyc, bus_b.Dmem2proc_tag, bus_b.Dmem2proc_data);
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_cpl_b: actual tag %0d required no completion", bus_b.Dmem2proc_tag);
            end else begin
                e = q_b.pop_front();
                chk("cpl_tag_b", 64'(bus_b.Dmem2proc_tag), 64'(e.tag));
                chk("cpl_data_b", bus_b.Dmem2proc_data, e.data);
                chk("cpl_cycle_b", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        set_bus(0, C_NONE, 32'h0, 64'h0);
        set_bus(1, C_NONE, 32'h0, 64'h0);
        @(negedge clk);
        chk("reset_busy_a", 64'(busy_a), 64'h0);
        chk("reset_tag_a", 64'(bus_a.Dmem2proc_tag), 64'h0);
        chk("reset_data_a", bus_a.Dmem2proc_data, 64'h0);
        chk("reset_busy_b", 64'(busy_b), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(1);

        // Store then load the same doubleword, back to back.
        issue(0, C_STORE, 32'h100, D1, 4'd1, 64'h0, "t1_store_resp");
        issue(0, C_LOAD,  32'h100, 64'h0, 4'd2, D1, "t1_load_resp");
        chk_busy(0, 15'h0003, "t1_busy");
        idle(8);

        // Offset bits ignored, high address bits alias, store->load ordering.
        issue(0, C_LOAD,  32'h104,  64'h0, 4'd1, D1, "t2_offset_resp");
        issue(0, C_LOAD,  32'h2100, 64'h0, 4'd2, D1, "t2_alias_resp");
        issue(0, C_STORE, 32'h208,  D2,    4'd3, 64'h0, "t2_store_resp");
        issue(0, C_LOAD,  32'h208,  64'h0, 4'd4, D2, "t2_fwd_resp");
        idle(8);

        // Command 3 and NONE are ignored (the cmd-3 "store" must not write).
        issue(0, C_BAD,  32'h100, 64'h0BAD0BAD_0BAD0BAD, 4'd0, 64'h0, "t4_cmd3_resp");
        issue(0, C_NONE, 32'h100, 64'h0, 4'd0, 64'h0, "t4_none_resp");
        idle(6);
        chk_busy(0, 15'h0000, "t4_busy");

        // Tag reuse boundary: tag 1 free again only at request cycle + 5.
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd1, D1, "t6_r0");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd2, D1, "t6_r1");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd3, D1, "t6_r2");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd4, D1, "t6_r3");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd5, D1, "t6_r4");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd1, D1, "t6_r5");
        chk_busy(0, 15'h001D, "t6_busy");
        idle(10);

        // Latency 20: exhaust all 15 tags, then retry until tag 1 frees.
        issue(1, C_STORE, 32'h40, D3, 4'd1, 64'h0, "t3_store_resp");
        idle(22);
        for (int i = 0; i < 15; i++) begin
            issue(1, C_LOAD, 32'h40, 64'h0, 4'(i + 1), D3, "t3_fill_resp");
        end
        issue(1, C_LOAD, 32'h40, 64'h0, 4'd0, 64'h0, "t3_full_resp");
        chk_busy(1, 15'h7FFF, "t3_busy_full");
        for (int i = 0; i < 4; i++) begin
            issue(1, C_LOAD, 32'h40, 64'h0, 4'd0, 64'h0, "t3_retry_wait");
        end
        issue(1, C_LOAD, 32'h40, 64'h0, 4'd1, D3, "t3_retry_ok");

        // Asynchronous reset mid-cycle while a completion is on the outputs.
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd1, D1, "t5_l0");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd2, D1, "t5_l1");
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd3, D1, "t5_l2");
        idle(1);
        #2;
        rst_a = 1'b1;
        q_a.delete();
        #1;
        chk("t5_rst_busy", 64'(busy_a), 64'h0);
        chk("t5_rst_tag", 64'(bus_a.Dmem2proc_tag), 64'h0);
        chk("t5_rst_data", bus_a.Dmem2proc_data, 64'h0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        idle(8);
        issue(0, C_LOAD, 32'h100, 64'h0, 4'd1, D1, "t5_after_rst");

        // Drain both scoreboards with a bounded wait.
        begin
            int w;
            w = 0;
            while ((q_a.size() != 0 || q_b.size() != 0) && w < 200) begin
                @(posedge clk);
                w++;
            end
            n_cmp++;
            if (q_a.size() != 0 || q_b.size() != 0) begin
                n_bad++;
                $display("FAIL drain_timeout: actual %0d/%0d pending required 0/0", q_a.size(), q_b.size());
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
